// File: rtl/pep_common_param_pkg.sv
// Shared constants and payload types for the PEP BLWE loader.
//   KS_IF_* / MOD_Q_W     : KS interface geometry and coefficient width
//   PID_W / RID_W         : PBS and register identifier widths
//   LDB_*                 : loader default depths
//   ldb_cmd_t             : queued load command
//   ldb_inflight_t        : per-request bookkeeping kept until the last word returns
package pep_common_param_pkg;

    localparam int unsigned KS_IF_COEF_NB      = 4;
    localparam int unsigned KS_IF_SUBW_NB      = 2;
    localparam int unsigned REGF_COEF_NB       = KS_IF_COEF_NB * KS_IF_SUBW_NB;
    localparam int unsigned MOD_Q_W            = 32;
    localparam int unsigned PID_W              = 5;
    localparam int unsigned RID_W              = 6;
    localparam int unsigned LDB_CMD_FIFO_DEPTH = 4;
    localparam int unsigned LDB_MAX_INFLIGHT   = 2;

    typedef struct packed {
        logic [RID_W-1:0] rid;
        logic [PID_W-1:0] pid;
        logic             pbs_last;
    } ldb_cmd_t;

    typedef struct packed {
        logic [PID_W-1:0] pid;
        logic             pbs_last;
    } ldb_inflight_t;

endpackage

// File: rtl/pep_ldb_fifo.sv
// Synchronous FIFO with occupancy reporting and a look-ahead of the second entry.
//   push_i/wr_data_i : write side; a push while full is taken only together with a pop
//   pop_i            : read side; ignored when empty
//   head_c/second_c  : first and second stored entries (second valid when count_o >= 2)
//   count_o          : registered occupancy, count_nxt_c its next-cycle value
//   full_o/empty_o   : registered flags
module pep_ldb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_c,
    output logic [WIDTH-1:0] second_c,
    output logic [CW-1:0]    count_o,
    output logic [CW-1:0]    count_nxt_c,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_idx_q, rd_idx_d;
    logic [AW-1:0]    wr_idx_q, wr_idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
        return (idx == AW'(DEPTH - 1)) ? '0 : idx + AW'(1);
    endfunction

    // Pointer and occupancy update
    always_comb begin
        pop_ok   = pop_i & ~empty_q;
        push_ok  = push_i & (~full_q | pop_i);
        rd_idx_d = pop_ok  ? idx_inc(rd_idx_q) : rd_idx_q;
        wr_idx_d = push_ok ? idx_inc(wr_idx_q) : wr_idx_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only read behind a valid count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx_q] <= wr_data_i;
        end
    end

    assign head_c      = mem_q[rd_idx_q];
    assign second_c    = mem_q[idx_inc(rd_idx_q)];
    assign count_o     = count_q;
    assign count_nxt_c = count_d;
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule

// File: rtl/pep_load_blwe_mc.sv
// Multi-command BLWE loader: register file -> KS BLWE RAM write port.
//   cmd_*               : load command input (rid, pid, pbs_last), buffered in a FIFO
//   regf_rd_req_*       : one read request per command, up to MAX_INFLIGHT outstanding
//   regf_rd_data_*      : returned words, in request order
//   blram_wr_*          : per-subword write port, one word registered per returned word
//   ldb_done            : pulse with the last write of each command
//   ldb_rcp_dur         : high while any command is outstanding
module pep_load_blwe_mc
    import pep_common_param_pkg::*;
#(
    parameter int unsigned CMD_FIFO_DEPTH = LDB_CMD_FIFO_DEPTH,
    parameter int unsigned MAX_INFLIGHT   = LDB_MAX_INFLIGHT
) (
    input  logic                                        clk,
    input  logic                                        a_rst_n,
    input  logic                                        cmd_vld,
    output logic                                        cmd_rdy,
    input  logic [RID_W-1:0]                            cmd_rid,
    input  logic [PID_W-1:0]                            cmd_pid,
    input  logic                                        cmd_pbs_last,
    output logic                                        regf_rd_req_vld,
    input  logic                                        regf_rd_req_rdy,
    output logic [RID_W-1:0]                            regf_rd_req_rid,
    input  logic                                        regf_rd_data_avail,
    input  logic [REGF_COEF_NB*MOD_Q_W-1:0]             regf_rd_data,
    input  logic                                        regf_rd_last_word,
    output logic [KS_IF_SUBW_NB-1:0]                    blram_wr_en,
    output logic [KS_IF_SUBW_NB*PID_W-1:0]              blram_wr_pid,
    output logic [KS_IF_SUBW_NB*KS_IF_COEF_NB*MOD_Q_W-1:0] blram_wr_data,
    output logic [KS_IF_SUBW_NB-1:0]                    blram_wr_pbs_last,
    output logic                                        ldb_done,
    output logic                                        ldb_rcp_dur
);

    localparam int unsigned CCW = $clog2(CMD_FIFO_DEPTH + 1);
    localparam int unsigned IFW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned DW  = REGF_COEF_NB * MOD_Q_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic               req_vld_q, req_vld_d;
    logic [RID_W-1:0]   req_rid_q, req_rid_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               rcp_dur_q;
    logic [KS_IF_SUBW_NB-1:0]       wr_en_q, wr_pbs_last_q;
    logic [KS_IF_SUBW_NB*PID_W-1:0] wr_pid_q;
    logic [DW-1:0]      wr_data_q;
    logic               done_q;

    ldb_cmd_t           cmd_in, cmd_head, cmd_second;
    logic [CCW-1:0]     cmd_count, cmd_count_nxt;
    logic               cmd_full, cmd_empty, cmd_push;
    ldb_inflight_t      ifl_in, ifl_head, ifl_second;
    logic [IFW-1:0]     ifl_count, ifl_count_nxt;
    logic               ifl_full, ifl_empty;
    logic               req_acc, ifl_pop, wr_vld;
    logic               unused_c;

    always_comb begin
        cmd_in   = '{rid: cmd_rid, pid: cmd_pid, pbs_last: cmd_pbs_last};
        ifl_in   = '{pid: cmd_head.pid, pbs_last: cmd_head.pbs_last};
        cmd_push = cmd_vld & cmd_rdy_q;
        req_acc  = req_vld_q & regf_rd_req_rdy;
        wr_vld   = regf_rd_data_avail & ~ifl_empty;
        ifl_pop  = wr_vld & regf_rd_last_word;
    end

    pep_ldb_fifo #(.WIDTH($bits(ldb_cmd_t)), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
        .clk         (clk),
        .a_rst_n     (a_rst_n),
        .push_i      (cmd_push),
        .wr_data_i   (cmd_in),
        .pop_i       (req_acc),
        .head_c      (cmd_head),
        .second_c    (cmd_second),
        .count_o     (cmd_count),
        .count_nxt_c (cmd_count_nxt),
        .full_o      (cmd_full),
        .empty_o     (cmd_empty)
    );

    // Inflight queue; its occupancy is the inflight count
    pep_ldb_fifo #(.WIDTH($bits(ldb_inflight_t)), .DEPTH(MAX_INFLIGHT)) u_ifl_fifo (
        .clk         (clk),
        .a_rst_n     (a_rst_n),
        .push_i      (req_acc),
        .wr_data_i   (ifl_in),
        .pop_i       (ifl_pop),
        .head_c      (ifl_head),
        .second_c    (ifl_second),
        .count_o     (ifl_count),
        .count_nxt_c (ifl_count_nxt),
        .full_o      (ifl_full),
        .empty_o     (ifl_empty)
    );

    assign unused_c = ^{cmd_full, ifl_second};

    // Request FSM; staying in REQ uses the FIFO's second entry as the next rid
    always_comb begin
        state_d   = state_q;
        req_rid_d = req_rid_q;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty && (ifl_count < IFW'(MAX_INFLIGHT))) begin
                    state_d   = ST_REQ;
                    req_rid_d = cmd_head.rid;
                end
            end
            ST_REQ: begin
                if (regf_rd_req_rdy) begin
                    if ((cmd_count >= CCW'(2)) && (ifl_count_nxt < IFW'(MAX_INFLIGHT))) begin
                        req_rid_d = cmd_second.rid;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_vld_d = (state_d == ST_REQ);
        cmd_rdy_d = (cmd_count_nxt != CCW'(CMD_FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q       <= ST_IDLE;
            req_vld_q     <= 1'b0;
            req_rid_q     <= '0;
            cmd_rdy_q     <= 1'b0;
            rcp_dur_q     <= 1'b0;
            wr_en_q       <= '0;
            wr_pid_q      <= '0;
            wr_data_q     <= '0;
            wr_pbs_last_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_vld_q     <= req_vld_d;
            req_rid_q     <= req_rid_d;
            cmd_rdy_q     <= cmd_rdy_d;
            rcp_dur_q     <= (ifl_count_nxt != '0);
            wr_en_q       <= {KS_IF_SUBW_NB{wr_vld}};
            // Subword s takes coefficients [s*KS_IF_COEF_NB +: KS_IF_COEF_NB]: same bit order as the word
            if (wr_vld) begin
                wr_pid_q  <= {KS_IF_SUBW_NB{ifl_head.pid}};
                wr_data_q <= regf_rd_data;
            end
            wr_pbs_last_q <= {KS_IF_SUBW_NB{ifl_pop & ifl_head.pbs_last}};
            done_q        <= ifl_pop;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks: data without a request, queue overrun
    always @(posedge clk) begin
        if (a_rst_n) begin
            assert (!(regf_rd_data_avail && ifl_empty));
            assert (ifl_count <= IFW'(MAX_INFLIGHT));
            assert (!(req_acc && ifl_full && !ifl_pop));
        end
    end
`endif

    assign cmd_rdy           = cmd_rdy_q;
    assign regf_rd_req_vld   = req_vld_q;
    assign regf_rd_req_rid   = req_rid_q;
    assign blram_wr_en       = wr_en_q;
    assign blram_wr_pid      = wr_pid_q;
    assign blram_wr_data     = wr_data_q;
    assign blram_wr_pbs_last = wr_pbs_last_q;
    assign ldb_done          = done_q;
    assign ldb_rcp_dur       = rcp_dur_q;

endmodule

// File: tb/tb_pep_load_blwe_mc.sv
// Directed bench for pep_load_blwe_mc: single command, pipelined commands,
// full command FIFO, coefficient split and reset in the middle of a BLWE.
module tb_pep_load_blwe_mc;
    import pep_common_param_pkg::*;

    localparam int unsigned DW = REGF_COEF_NB * MOD_Q_W;

    logic                             clk = 1'b0;
    logic                             a_rst_n;
    logic                             cmd_vld, cmd_rdy, cmd_pbs_last;
    logic [RID_W-1:0]                 cmd_rid;
    logic [PID_W-1:0]                 cmd_pid;
    logic                             regf_rd_req_vld, regf_rd_req_rdy;
    logic [RID_W-1:0]                 regf_rd_req_rid;
    logic                             regf_rd_data_avail, regf_rd_last_word;
    logic [DW-1:0]                    regf_rd_data;
    logic [KS_IF_SUBW_NB-1:0]         blram_wr_en, blram_wr_pbs_last;
    logic [KS_IF_SUBW_NB*PID_W-1:0]   blram_wr_pid;
    logic [DW-1:0]                    blram_wr_data;
    logic                             ldb_done, ldb_rcp_dur;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int done_ref;

    always #5 clk = ~clk;

    always @(posedge clk) if (ldb_done === 1'b1) done_cnt++;

    pep_load_blwe_mc dut (
        .clk                (clk),
        .a_rst_n            (a_rst_n),
        .cmd_vld            (cmd_vld),
        .cmd_rdy            (cmd_rdy),
        .cmd_rid            (cmd_rid),
        .cmd_pid            (cmd_pid),
        .cmd_pbs_last       (cmd_pbs_last),
        .regf_rd_req_vld    (regf_rd_req_vld),
        .regf_rd_req_rdy    (regf_rd_req_rdy),
        .regf_rd_req_rid    (regf_rd_req_rid),
        .regf_rd_data_avail (regf_rd_data_avail),
        .regf_rd_data       (regf_rd_data),
        .regf_rd_last_word  (regf_rd_last_word),
        .blram_wr_en        (blram_wr_en),
        .blram_wr_pid       (blram_wr_pid),
        .blram_wr_data      (blram_wr_data),
        .blram_wr_pbs_last  (blram_wr_pbs_last),
        .ldb_done           (ldb_done),
        .ldb_rcp_dur        (ldb_rcp_dur)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int rid, input int pid, input bit last);
        cmd_vld      = 1'b1;
        cmd_rid      = RID_W'(rid);
        cmd_pid      = PID_W'(pid);
        cmd_pbs_last = last;
    endtask

    task automatic word(input logic [DW-1:0] d, input bit last);
        regf_rd_data_avail = 1'b1;
        regf_rd_data       = d;
        regf_rd_last_word  = last;
    endtask

    task automatic no_word();
        regf_rd_data_avail = 1'b0;
        regf_rd_last_word  = 1'b0;
    endtask

    // Word whose coefficient i holds base+i
    function automatic logic [DW-1:0] mkword(input int base);
        logic [DW-1:0] w;
        for (int i = 0; i < int'(REGF_COEF_NB); i++) w[i*MOD_Q_W +: MOD_Q_W] = MOD_Q_W'(base + i);
        return w;
    endfunction

    function automatic logic [2*PID_W-1:0] pid2(input int p);
        return {PID_W'(p), PID_W'(p)};
    endfunction

    initial begin
        a_rst_n = 1'b0;
        cmd_vld = 1'b0; cmd_rid = '0; cmd_pid = '0; cmd_pbs_last = 1'b0;
        regf_rd_req_rdy = 1'b1;
        regf_rd_data = '0;
        no_word();

        // Reset state
        #2;
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_req_vld", regf_rd_req_vld, 0);
        chk("rst_wr_en", blram_wr_en, 0);
        chk("rst_done", ldb_done, 0);
        chk("rst_rcp", ldb_rcp_dur, 0);
        tick(); tick();
        a_rst_n = 1'b1;
        tick();
        chk("rel_cmd_rdy", cmd_rdy, 1);

        // Single command, 4-word BLWE
        send_cmd(3, 7, 1'b1);
        tick();
        cmd_vld = 1'b0;
        tick();
        chk("t1_req_vld", regf_rd_req_vld, 1);
        chk("t1_req_rid", regf_rd_req_rid, 3);
        tick();
        chk("t1_req_vld_drop", regf_rd_req_vld, 0);
        chk("t1_rcp_on", ldb_rcp_dur, 1);
        word(mkword(0), 1'b0);
        tick();
        chk("t1_w0_en", blram_wr_en, 2'b11);
        chk("t1_w0_sub0", blram_wr_data[127:0], 128'h00000003_00000002_00000001_00000000);
        chk("t1_w0_sub1", blram_wr_data[255:128], 128'h00000007_00000006_00000005_00000004);
        chk("t1_w0_pid", blram_wr_pid, 10'h0E7);
        chk("t1_w0_pbs_last", blram_wr_pbs_last, 0);
        chk("t1_w0_done", ldb_done, 0);
        word(mkword(8), 1'b0);
        tick();
        word(mkword(16), 1'b0);
        tick();
        chk("t1_w2_rcp", ldb_rcp_dur, 1);
        chk("t1_w2_pbs_last", blram_wr_pbs_last, 0);
        word(mkword(24), 1'b1);
        tick();
        chk("t1_w3_en", blram_wr_en, 2'b11);
        chk("t1_w3_data", blram_wr_data, mkword(24));
        chk("t1_w3_pbs_last", blram_wr_pbs_last, 2'b11);
        chk("t1_w3_done", ldb_done, 1);
        chk("t1_w3_rcp_off", ldb_rcp_dur, 0);
        no_word();
        tick();
        chk("t1_done_pulse", ldb_done, 0);
        chk("t1_en_off", blram_wr_en, 0);

        // Four pipelined commands, two words each
        done_ref = done_cnt;
        send_cmd(10, 1, 1'b0);
        tick();
        send_cmd(11, 2, 1'b0);
        tick();
        chk("t2_reqA", regf_rd_req_rid, 10);
        send_cmd(12, 3, 1'b0);
        tick();
        chk("t2_reqB_vld", regf_rd_req_vld, 1);
        chk("t2_reqB_rid", regf_rd_req_rid, 11);
        send_cmd(13, 4, 1'b1);
        tick();
        cmd_vld = 1'b0;
        chk("t2_limit_vld", regf_rd_req_vld, 0);
        tick();
        chk("t2_limit_vld2", regf_rd_req_vld, 0);
        word(mkword(100), 1'b0);
        tick();
        chk("t2_A0_pid", blram_wr_pid, pid2(1));
        chk("t2_noC_yet", regf_rd_req_vld, 0);
        word(mkword(108), 1'b1);
        tick();
        chk("t2_A_done", ldb_done, 1);
        chk("t2_noC_at_last", regf_rd_req_vld, 0);
        word(mkword(200), 1'b0);
        tick();
        chk("t2_reqC_vld", regf_rd_req_vld, 1);
        chk("t2_reqC_rid", regf_rd_req_rid, 12);
        chk("t2_B0_pid", blram_wr_pid, pid2(2));
        word(mkword(208), 1'b1);
        tick();
        chk("t2_reqD_vld", regf_rd_req_vld, 1);
        chk("t2_reqD_rid", regf_rd_req_rid, 13);
        chk("t2_B_done", ldb_done, 1);
        chk("t2_B_rcp", ldb_rcp_dur, 1);
        no_word();
        tick();
        chk("t2_reqD_drop", regf_rd_req_vld, 0);
        word(mkword(300), 1'b0);
        tick();
        chk("t2_C0_pid", blram_wr_pid, pid2(3));
        word(mkword(308), 1'b1);
        tick();
        chk("t2_C_done", ldb_done, 1);
        chk("t2_C_pbs_last", blram_wr_pbs_last, 0);
        word(mkword(400), 1'b0);
        tick();
        chk("t2_D0_pid", blram_wr_pid, pid2(4));
        chk("t2_D0_pbs_last", blram_wr_pbs_last, 0);
        word(mkword(408), 1'b1);
        tick();
        chk("t2_D_pbs_last", blram_wr_pbs_last, 2'b11);
        chk("t2_D_done", ldb_done, 1);
        chk("t2_D_rcp_off", ldb_rcp_dur, 0);
        no_word();
        tick();
        chk("t2_done_count", done_cnt - done_ref, 4);

        // Command FIFO full while the register file stalls
        done_ref = done_cnt;
        regf_rd_req_rdy = 1'b0;
        send_cmd(20, 20, 1'b0);
        tick();
        send_cmd(21, 21, 1'b0);
        tick();
        send_cmd(22, 22, 1'b0);
        tick();
        send_cmd(23, 23, 1'b0);
        tick();
        chk("t3_full_rdy", cmd_rdy, 0);
        chk("t3_stall_vld", regf_rd_req_vld, 1);
        chk("t3_stall_rid", regf_rd_req_rid, 20);
        send_cmd(24, 24, 1'b0);
        tick();
        chk("t3_full_rdy2", cmd_rdy, 0);
        chk("t3_stall_rid2", regf_rd_req_rid, 20);
        regf_rd_req_rdy = 1'b1;
        tick();
        chk("t3_pop_rdy", cmd_rdy, 1);
        chk("t3_next_rid", regf_rd_req_rid, 21);
        regf_rd_req_rdy = 1'b0;
        tick();
        chk("t3_fifth_taken", cmd_rdy, 0);
        cmd_vld = 1'b0;
        regf_rd_req_rdy = 1'b1;
        tick();
        chk("t3_limit_vld", regf_rd_req_vld, 0);
        for (int k = 0; k < 5; k++) begin
            word(mkword(k), 1'b1);
            tick();
            chk("t3_drain_pid", blram_wr_pid, pid2(20 + k));
            chk("t3_drain_done", ldb_done, 1);
            no_word();
            tick(); tick(); tick();
        end
        chk("t3_done_count", done_cnt - done_ref, 5);

        // Reset after 2 of 4 words
        done_ref = done_cnt;
        send_cmd(30, 9, 1'b1);
        tick();
        cmd_vld = 1'b0;
        tick();
        chk("t4_req_rid", regf_rd_req_rid, 30);
        tick();
        word(mkword(500), 1'b0);
        tick();
        word(mkword(508), 1'b0);
        tick();
        chk("t4_pre_en", blram_wr_en, 2'b11);
        no_word();
        a_rst_n = 1'b0;
        #1;
        chk("t4_rst_en", blram_wr_en, 0);
        chk("t4_rst_pid", blram_wr_pid, 0);
        chk("t4_rst_data", blram_wr_data, 0);
        chk("t4_rst_rcp", ldb_rcp_dur, 0);
        chk("t4_rst_cmd_rdy", cmd_rdy, 0);
        chk("t4_rst_vld", regf_rd_req_vld, 0);
        tick(); tick();
        a_rst_n = 1'b1;
        tick();
        chk("t4_rel_cmd_rdy", cmd_rdy, 1);
        chk("t4_rel_done", ldb_done, 0);
        chk("t4_rel_rcp", ldb_rcp_dur, 0);
        send_cmd(31, 10, 1'b0);
        tick();
        cmd_vld = 1'b0;
        tick();
        chk("t4_new_rid", regf_rd_req_rid, 31);
        tick();
        word(mkword(600), 1'b0);
        tick();
        word(mkword(608), 1'b1);
        tick();
        chk("t4_new_pid", blram_wr_pid, pid2(10));
        chk("t4_new_done", ldb_done, 1);
        no_word();
        tick();
        chk("t4_done_count", done_cnt - done_ref, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pep_load_blwe_mc.md
Name: pep_load_blwe_mc

Overview:
Multi-command BLWE loader between the register file and the key-switch BLWE RAM write interface.
- Accepts load commands (register id, PID, pbs_last flag) into a command FIFO.
- Issues one register-file read request per command and splits each returned word into KS_IF_SUBW_NB subwords for the KS input.
- Successor to the single-command loader: pipelines up to MAX_INFLIGHT commands, so the request for command N+1 overlaps the data return of command N. Adds per-command done reporting and a reception-duration counter pulse.

Parameters:
KS_IF_COEF_NB, 4, coefficients per KS subword
KS_IF_SUBW_NB, 2, subwords per register-file word; REGF_COEF_NB = KS_IF_COEF_NB*KS_IF_SUBW_NB
MOD_Q_W, 32, coefficient width
PID_W, 5, PBS identifier width
RID_W, 6, register identifier width
CMD_FIFO_DEPTH, 4, command FIFO depth; power of 2, >= 2
MAX_INFLIGHT, 2, maximum requested-but-not-fully-received commands; 1..CMD_FIFO_DEPTH

Ports:
clk  in  1  clock
a_rst_n  in  1  asynchronous active-low reset
cmd_vld  in  1  load command valid
cmd_rdy  out  1  command FIFO not full
cmd_rid  in  RID_W  source register id
cmd_pid  in  PID_W  destination PBS id
cmd_pbs_last  in  1  command is the last of its PBS batch
regf_rd_req_vld  out  1  read request valid
regf_rd_req_rdy  in  1  read request accepted
regf_rd_req_rid  out  RID_W  register to read
regf_rd_data_avail  in  1  read data word valid
regf_rd_data  in  REGF_COEF_NB*MOD_Q_W  read data word
regf_rd_last_word  in  1  last word of current BLWE; qualified by avail
blram_wr_en  out  KS_IF_SUBW_NB  per-subword write enable
blram_wr_pid  out  KS_IF_SUBW_NB*PID_W  per-subword PID
blram_wr_data  out  KS_IF_SUBW_NB*KS_IF_COEF_NB*MOD_Q_W  per-subword data
blram_wr_pbs_last  out  KS_IF_SUBW_NB  set on the last word of a pbs_last command
ldb_done  out  1  one-cycle pulse when a command's last word is written
ldb_rcp_dur  out  1  high on every cycle with at least one inflight command

Behaviour:
- All outputs are registered. Reset value is 0 for every output except cmd_rdy, which is 1 once out of reset. Reset clears both FIFOs, all counters and the FSM.
- Command FIFO:
  - Push on cmd_vld & cmd_rdy. cmd_rdy = not full.
  - Push and pop in the same cycle when full is legal; occupancy is unchanged.
- Request FSM:
  - IDLE: if FIFO not empty and inflight < MAX_INFLIGHT, go to REQ.
  - REQ: regf_rd_req_vld=1, rid taken from the FIFO head. On rdy: pop the FIFO, push {pid, pbs_last} into the inflight queue (depth MAX_INFLIGHT), inflight++, then go to IDLE.
  - Back-to-back requests: REQ may stay in REQ if the next head is ready and inflight+1 < MAX_INFLIGHT after the increment.
  - vld holds stable until rdy; the rid does not change while vld is high.
- Data path:
  - Data returns in request order.
  - Each avail word is registered (1-cycle latency): blram_wr_en = all ones; subword s gets coefficients [s*KS_IF_COEF_NB +: KS_IF_COEF_NB]; wr_pid is the inflight-queue head pid on every subword.
  - On avail & last_word:
    - wr_pbs_last = head pbs_last on every subword.
    - Pop the inflight queue, inflight--, and pulse ldb_done one cycle after.
  - A request acceptance and a last_word in the same cycle leave inflight unchanged; the queue pushes and pops together.
- Error cases (assertions, not recovery):
  - avail with an empty inflight queue.
  - inflight > MAX_INFLIGHT.
- Reset mid-transfer: all inflight state is dropped. Any data arriving after reset is ignored because the queue is empty; this is flagged by assertion only under simulation.
- ldb_rcp_dur = (inflight != 0), registered.

Decomposition:
- Add to pep_common_param_pkg:
  - ldb_cmd_t {rid, pid, pbs_last}
  - ldb_inflight_t {pid, pbs_last}
  - LDB_MAX_INFLIGHT default constant
- One sub-module, pep_ldb_fifo: a parametrised width/depth synchronous FIFO with full/empty, instantiated twice (command FIFO, inflight queue).

Test Plan:
- Single command (rid=3, pid=7, pbs_last=1), 4-word BLWE, rdy always 1 → one request with rid=3; 4 writes with pid=7 on both subwords; pbs_last only on word 4; ldb_done 1 cycle after word 4; rcp_dur high from request acceptance through the last word.
- 4 commands back to back, MAX_INFLIGHT=2, data returned with 3-cycle latency → second request issued before the first BLWE completes; the third request is not issued until the first last_word; pids appear in order; 4 done pulses.
- Command FIFO full (4 pushed, regf_rd_req_rdy=0) → cmd_rdy=0. A 5th cmd_vld is not accepted until rdy=1 pops one entry; the rid is stable throughout the stall.
- Word 0 coefficients 0..7 with KS_IF_COEF_NB=4 → subword0 data {0,1,2,3}, subword1 data {4,5,6,7}.
- Request acceptance coincides with last_word of the previous command → inflight count unchanged; next write carries the new pid.
- Assert a_rst_n low mid-BLWE after 2 of 4 words → all outputs 0 at once, cmd_rdy=1 after release, no done pulse; a new command then completes normally.
